// File: rtl/immediate_encoder_pkg.sv
// Shared definitions for the immediate encoder.
// Holds the Format and Control codes, field widths and placements, the FSM state type, the
// per-beat record, and helpers that pick the MOVZ beats.
// There are no ports; the other files import this package.
package immediate_encoder_pkg;

  // Format codes. Codes 101-111 are reserved.
  localparam logic [2:0] FmtI    = 3'b000;
  localparam logic [2:0] FmtD    = 3'b001;
  localparam logic [2:0] FmtB    = 3'b010;
  localparam logic [2:0] FmtCb   = 3'b011;
  localparam logic [2:0] FmtMovz = 3'b100;

  // Sign-extender control codes. MOVZ beats use 100+k for 16-bit chunk k.
  localparam logic [2:0] CtrlI     = 3'b000;
  localparam logic [2:0] CtrlD     = 3'b001;
  localparam logic [2:0] CtrlB     = 3'b010;
  localparam logic [2:0] CtrlCb    = 3'b011;
  localparam logic [2:0] CtrlMovz0 = 3'b100;
  localparam logic [2:0] CtrlMovz1 = 3'b101;
  localparam logic [2:0] CtrlMovz2 = 3'b110;
  localparam logic [2:0] CtrlMovz3 = 3'b111;

  // Field widths and their bit position inside the packed instruction.
  localparam int unsigned InstrWidth = 26;
  localparam int unsigned IWidth     = 12;
  localparam int unsigned DWidth     = 9;
  localparam int unsigned BWidth     = 26;
  localparam int unsigned CbWidth    = 19;
  localparam int unsigned ChunkWidth = 16;
  localparam int unsigned IShift     = 10;
  localparam int unsigned DShift     = 12;
  localparam int unsigned CbShift    = 5;
  localparam int unsigned ChunkShift = 5;
  localparam int unsigned NumChunks  = 4;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  // One output beat.
  typedef struct packed {
    logic [InstrWidth-1:0] bits;
    logic [2:0]            ctrl;
    logic                  last;
  } beat_t;

  // Bit k is set when 16-bit chunk k of the value is non-zero.
  function automatic logic [NumChunks-1:0] chunk_mask(input logic [63:0] value);
    logic [NumChunks-1:0] m;
    m = '0;
    for (int k = 0; k < NumChunks; k++) begin
      m[k] = |value[ChunkWidth*k +: ChunkWidth];
    end
    return m;
  endfunction

  // Beat for the lowest pending chunk.
  // An empty mask only happens for Value=0. In that case it yields the single all-zero
  // chunk-0 beat with Last set.
  function automatic beat_t movz_beat(input logic [63:0] value, input logic [NumChunks-1:0] mask);
    logic [1:0]            k;
    logic [ChunkWidth-1:0] chunk;
    beat_t                 b;
    k = 2'd0;
    for (int i = NumChunks - 1; i >= 0; i--) begin
      if (mask[i]) k = 2'(i);
    end
    chunk  = value[ChunkWidth*k +: ChunkWidth];
    b.bits = InstrWidth'(chunk) << ChunkShift;
    b.ctrl = CtrlMovz0 | {1'b0, k};
    // Last when at most one bit is still pending.
    b.last = (mask & (mask - 4'd1)) == 4'd0;
    return b;
  endfunction

endpackage

// File: rtl/immediate_encoder_range_check.sv
// Combinational range check and field packing for the single-beat formats.
// Ports:
//   value_i  - the 64-bit target immediate.
//   format_i - the Format code.
//   fits_o   - the value is encodable in the format. This is always 1 for MOVZ and 0 for the
//              reserved codes.
//   bits_o   - the packed instruction field. It is zero when fits_o is 0 and for MOVZ.
module range_check
  import immediate_encoder_pkg::*;
(
  input  logic [63:0]           value_i,
  input  logic [2:0]            format_i,
  output logic                  fits_o,
  output logic [InstrWidth-1:0] bits_o
);

  // True when value[63:w-1] is all zeros or all ones, so the value is a w-bit signed quantity.
  function automatic logic upper_equal(input logic [63:0] v, input int unsigned w);
    logic [63:0] hi_mask;
    hi_mask = {64{1'b1}} << (w - 1);
    return ((v & hi_mask) == hi_mask) || ((v & hi_mask) == 64'd0);
  endfunction

  logic [InstrWidth-1:0] packed_bits;

  always_comb begin
    fits_o      = 1'b0;
    packed_bits = '0;
    case (format_i)
      FmtI: begin
        fits_o      = upper_equal(value_i, IWidth);
        packed_bits = InstrWidth'(value_i[IWidth-1:0]) << IShift;
      end
      FmtD: begin
        fits_o      = upper_equal(value_i, DWidth);
        packed_bits = InstrWidth'(value_i[DWidth-1:0]) << DShift;
      end
      FmtB: begin
        fits_o      = upper_equal(value_i, BWidth);
        packed_bits = InstrWidth'(value_i[BWidth-1:0]);
      end
      FmtCb: begin
        fits_o      = upper_equal(value_i, CbWidth);
        packed_bits = InstrWidth'(value_i[CbWidth-1:0]) << CbShift;
      end
      FmtMovz: begin
        // Any value can be materialised chunk by chunk.
        fits_o = 1'b1;
      end
      default: begin
        fits_o = 1'b0;
      end
    endcase
    bits_o = fits_o ? packed_bits : '0;
  end

endmodule

// File: rtl/immediate_encoder.sv
// Encodes a 64-bit immediate into instruction fields, one output beat at a time.
// I, D, B and CB requests, and the reserved formats, produce a single beat. MOVZ produces one
// beat per non-zero 16-bit chunk, lowest chunk first.
// Ports:
//   Clk, Reset      - the clock, and a synchronous active-high reset.
//   InValid/InReady - the request handshake, carrying Value (64 bits) and Format (3 bits).
//   OutValid/OutReady - the output beat handshake.
//   InstructionBits - the packed field (26 bits).
//   Control         - the sign-extender control code (3 bits).
//   Last            - marks the final beat of a request.
//   RangeError      - Value is not encodable, or the format is reserved.
module immediate_encoder
  import immediate_encoder_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [63:0]           Value,
  input  logic [2:0]            Format,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [InstrWidth-1:0] InstructionBits,
  output logic [2:0]            Control,
  output logic                  Last,
  output logic                  RangeError
);

  state_e                state_q;
  logic [63:0]           val_q;
  logic [2:0]            fmt_q;
  logic [NumChunks-1:0]  mask_q;
  logic                  out_valid_q;
  logic [InstrWidth-1:0] bits_q;
  logic [2:0]            ctrl_q;
  logic                  last_q;
  logic                  rerr_q;

  logic                  rc_fits;
  logic [InstrWidth-1:0] rc_bits;
  logic [NumChunks-1:0]  in_mask;
  logic [NumChunks-1:0]  nxt_mask;
  beat_t                 acc_beat;
  beat_t                 nxt_beat;

  // The range check looks at the incoming request, so the first beat can be registered at
  // accept time.
  range_check u_range_check (
    .value_i  (Value),
    .format_i (Format),
    .fits_o   (rc_fits),
    .bits_o   (rc_bits)
  );

  always_comb begin
    in_mask  = chunk_mask(Value);
    acc_beat = movz_beat(Value, in_mask);
    // Each MOVZ handshake retires the lowest pending chunk.
    nxt_mask = mask_q & (mask_q - 4'd1);
    nxt_beat = movz_beat(val_q, nxt_mask);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      val_q       <= '0;
      fmt_q       <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      bits_q      <= '0;
      ctrl_q      <= '0;
      last_q      <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (InValid) begin
            state_q     <= StEmit;
            val_q       <= Value;
            fmt_q       <= Format;
            out_valid_q <= 1'b1;
            if (Format == FmtMovz) begin
              mask_q <= in_mask;
              bits_q <= acc_beat.bits;
              ctrl_q <= acc_beat.ctrl;
              last_q <= acc_beat.last;
              rerr_q <= 1'b0;
            end else begin
              mask_q <= '0;
              bits_q <= rc_bits;
              ctrl_q <= Format;
              last_q <= 1'b1;
              rerr_q <= ~rc_fits;
            end
          end
        end
        StEmit: begin
          if (OutReady) begin
            if (last_q) begin
              state_q     <= StIdle;
              mask_q      <= '0;
              out_valid_q <= 1'b0;
              bits_q      <= '0;
              ctrl_q      <= '0;
              last_q      <= 1'b0;
              rerr_q      <= 1'b0;
            end else if (fmt_q == FmtMovz) begin
              mask_q <= nxt_mask;
              bits_q <= nxt_beat.bits;
              ctrl_q <= nxt_beat.ctrl;
              last_q <= nxt_beat.last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign InReady         = (state_q == StIdle);
  assign OutValid        = out_valid_q;
  assign InstructionBits = bits_q;
  assign Control         = ctrl_q;
  assign Last            = last_q;
  assign RangeError      = rerr_q;

endmodule

// File: tb/tb_immediate_encoder.sv
module tb_immediate_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [63:0] Value;
  logic [2:0]  Format;
  logic        OutValid;
  logic        OutReady;
  logic [25:0] InstructionBits;
  logic [2:0]  Control;
  logic        Last;
  logic        RangeError;

  int n_checks = 0;
  int n_errors = 0;

  immediate_encoder dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .InValid         (InValid),
    .InReady         (InReady),
    .Value           (Value),
    .Format          (Format),
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .InstructionBits (InstructionBits),
    .Control         (Control),
    .Last            (Last),
    .RangeError      (RangeError)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [25:0] bits;
    logic [2:0]  ctrl;
    logic        last;
    logic        rerr;
  } exp_beat_t;

  exp_beat_t exp_q[$];

  function automatic logic [63:0] sext(input logic [63:0] x, input int w);
    logic signed [63:0] t;
    t = $signed(x << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Reference model: the list of beats a request must produce.
  task automatic build_expected(input logic [63:0] v, input logic [2:0] f);
    int                 wd;
    int                 sh;
    logic signed [63:0] sv;
    logic signed [63:0] lim;
    logic               fits;
    exp_beat_t          b;
    exp_q.delete();
    if (f < 3'd4) begin
      case (f)
        3'd0:    begin wd = 12; sh = 10; end
        3'd1:    begin wd = 9;  sh = 12; end
        3'd2:    begin wd = 26; sh = 0;  end
        default: begin wd = 19; sh = 5;  end
      endcase
      sv     = $signed(v);
      lim    = 64'sd1 <<< (wd - 1);
      fits   = (sv >= -lim) && (sv < lim);
      b.bits = fits ? 26'((v & ((64'd1 << wd) - 64'd1)) << sh) : 26'd0;
      b.ctrl = f;
      b.last = 1'b1;
      b.rerr = !fits;
      exp_q.push_back(b);
    end else if (f == 3'd4) begin
      for (int k = 0; k < 4; k++) begin
        if (v[16*k +: 16] != 16'd0) begin
          b.bits = 26'(v[16*k +: 16]) << 5;
          b.ctrl = 3'(4 + k);
          b.last = 1'b0;
          b.rerr = 1'b0;
          exp_q.push_back(b);
        end
      end
      if (exp_q.size() == 0) begin
        b.bits = 26'd0;
        b.ctrl = 3'd4;
        b.last = 1'b0;
        b.rerr = 1'b0;
        exp_q.push_back(b);
      end
      exp_q[exp_q.size() - 1].last = 1'b1;
    end else begin
      b.bits = 26'd0;
      b.ctrl = f;
      b.last = 1'b1;
      b.rerr = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Value contributed by an observed beat after sign extension.
  function automatic logic [63:0] decode(input logic [25:0] bits, input logic [2:0] ctrl);
    case (ctrl)
      3'd0:    return sext(64'(bits[21:10]), 12);
      3'd1:    return sext(64'(bits[20:12]), 9);
      3'd2:    return sext(64'(bits[25:0]), 26);
      3'd3:    return sext(64'(bits[23:5]), 19);
      default: return 64'(bits[20:5]) << (16 * (int'(ctrl) - 4));
    endcase
  endfunction

  // One request. A negative stall picks a random stall of 0..2 cycles before each beat.
  task automatic run_req(input logic [63:0] v, input logic [2:0] f, input int stall);
    logic [63:0] acc;
    int          n;
    exp_beat_t   e;
    build_expected(v, f);
    check("in_ready_idle", InReady, 1'b1);
    InValid = 1'b1;
    Value   = v;
    Format  = f;
    @(posedge Clk);
    #1;
    // Garbage inputs while busy must be ignored.
    InValid = 1'($urandom_range(0, 1));
    Value   = {$urandom, $urandom};
    Format  = 3'($urandom);
    acc     = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int s = 0; s <= n; s++) begin
        check("out_valid", OutValid, 1'b1);
        check("in_ready_busy", InReady, 1'b0);
        check("instr_bits", InstructionBits, e.bits);
        check("control", Control, e.ctrl);
        check("last", Last, e.last);
        check("range_error", RangeError, e.rerr);
        if (s == n) acc |= decode(InstructionBits, Control);
        OutReady = (s == n);
        @(posedge Clk);
        #1;
      end
      OutReady = 1'b0;
    end
    InValid = 1'b0;
    check("out_valid_after", OutValid, 1'b0);
    check("in_ready_after", InReady, 1'b1);
    if (!exp_q[0].rerr) check("or_of_beats", acc, v);
  endtask

  initial begin
    logic [63:0] v;
    logic [2:0]  f;
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Value    = '0;
    Format   = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", OutValid, 1'b0);
    check("rst_in_ready", InReady, 1'b1);
    check("rst_bits", InstructionBits, 26'd0);
    check("rst_control", Control, 3'd0);
    check("rst_last", Last, 1'b0);
    check("rst_range_error", RangeError, 1'b0);
    Reset = 1'b0;

    run_req(64'h7FF, 3'd0, 0);
    run_req(64'h800, 3'd0, 0);
    run_req({64{1'b1}}, 3'd0, 1);
    run_req(64'hFFFF_FFFF_FFFF_F800, 3'd0, 0);
    run_req(64'hFF, 3'd1, 0);
    run_req(64'h100, 3'd1, 0);
    run_req(64'hFFFF_FFFF_FFFF_FF00, 3'd1, 0);
    run_req(64'h1FF_FFFF, 3'd2, 0);
    run_req(64'h200_0000, 3'd2, 0);
    run_req(64'h3_FFFF, 3'd3, 0);
    run_req(64'hFFFF_FFFF_FFFC_0000, 3'd3, 0);
    run_req(64'h4_0000, 3'd3, 0);
    run_req(64'h0001_0000_0000_BEEF, 3'd4, 0);
    run_req(64'h1234_5678_9ABC_DEF0, 3'd4, 3);
    run_req(64'h0, 3'd4, 1);
    run_req(64'h1234, 3'd5, 0);
    run_req(64'hDEAD, 3'd6, 0);
    run_req(64'hBEEF, 3'd7, 2);

    // Reset while the second MOVZ beat is pending, with a simultaneous handshake.
    InValid = 1'b1;
    Value   = 64'h0001_0000_0000_BEEF;
    Format  = 3'd4;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    check("abort_beat1_ctrl", Control, 3'd4);
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_beat2_ctrl", Control, 3'd7);
    check("abort_beat2_valid", OutValid, 1'b1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("abort_out_valid", OutValid, 1'b0);
    check("abort_in_ready", InReady, 1'b1);
    check("abort_bits", InstructionBits, 26'd0);
    check("abort_control", Control, 3'd0);
    check("abort_last", Last, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check("abort_no_beats", OutValid, 1'b0);
    end
    OutReady = 1'b0;
    run_req(64'h0000_ABCD_0000_0001, 3'd4, -1);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       v = {$urandom, $urandom};
        1:       v = sext({$urandom, $urandom}, int'($urandom_range(8, 27)));
        default: begin
          v = {$urandom, $urandom};
          for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 0) v[16*k +: 16] = 16'd0;
          end
        end
      endcase
      run_req(v, f, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
